// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA word sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the slice handed to the 4-bit CLA each step.
   localparam int NIB_W = 4;

   // Register latency of the standard CLA instance beside the sequencer.
   localparam int CLA_LAT_DEF = 2;

endpackage

// File: rtl/cla_word_sequencer.sv
// Feeds a WIDTH-bit add through an external registered 4-bit CLA one nibble at a time, LSB first.
// Latency: out_valid rises NIB*(CLA_LAT+1) edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, nothing is queued.
module cla_word_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int CLA_LAT = CLA_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [3:0]       cla_a,
   output logic [3:0]       cla_b,
   output logic             cla_c0,
   input  logic [3:0]       cla_s,
   input  logic             cla_c4
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int CNT_W = $clog2(CLA_LAT + 1);

   generate
      if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
         $error("cla_word_sequencer: WIDTH must be a multiple of 4 and at least 4");
      end
      if (CLA_LAT < 1) begin : g_bad_lat
         $error("cla_word_sequencer: CLA_LAT must be at least 1");
      end
   endgenerate

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             cout_q;
   logic             ovf_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sample;
   logic             last_nib;

   // The CLA output is trusted only after the full latency has elapsed for this step's inputs.
   assign sample   = (state == STEP) && (cnt_q == CNT_W'(CLA_LAT));
   assign last_nib = (idx_q == IDX_W'(NIB - 1));

   assign sum  = result_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, handshake and CLA drive; CLA inputs idle at zero outside STEP.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      cla_a     = '0;
      cla_b     = '0;
      cla_c0    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = STEP;
            end
         end
         STEP: begin
            cla_a  = a_q[NIB_W*int'(idx_q) +: NIB_W];
            cla_b  = b_q[NIB_W*int'(idx_q) +: NIB_W];
            cla_c0 = carry_q;
            if (sample && last_nib) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, step timing, nibble result assembly and carry chaining.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  carry_q  <= cin;
                  result_q <= '0;
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
                  idx_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            STEP: begin
               if (sample) begin
                  result_q[NIB_W*int'(idx_q) +: NIB_W] <= cla_s;
                  carry_q <= cla_c4;
                  cnt_q   <= '0;
                  if (last_nib) begin
                     cout_q <= cla_c4;
                     // Sign of the word result is the top bit of the final nibble.
                     ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (cla_s[NIB_W-1] != a_q[WIDTH-1]);
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Scoreboard bench: two sequencers (16-bit/lat 2 and 8-bit/lat 3) each driving a behavioural CLA.
// Latency: checked per transaction against NIB*(CLA_LAT+1).
// Backpressure: out_ready stalls and ignored in_valid pulses exercised in DONE.
`timescale 1ns/1ps
module tb_cla_word_sequencer;

   localparam int W0 = 16;
   localparam int L0 = 2;
   localparam int N0 = W0 / 4;
   localparam int W1 = 8;
   localparam int L1 = 3;
   localparam int N1 = W1 / 4;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT0 signals
   logic          iv0, ir0, ci0, ov0, or0, co0, of0, cc0, c40;
   logic [W0-1:0] a0, b0, s0;
   logic [3:0]    ca0, cb0, cs0;
   // DUT1 signals
   logic          iv1, ir1, ci1, ov1, or1, co1, of1, cc1, c41;
   logic [W1-1:0] a1, b1, s1;
   logic [3:0]    ca1, cb1, cs1;

   logic [33:0] exp0_q[$];
   logic [33:0] exp1_q[$];
   int          acc0_q[$];
   int          acc1_q[$];

   cla_word_sequencer #(.WIDTH(W0), .CLA_LAT(L0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(ci0),
      .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .ovf(of0),
      .cla_a(ca0), .cla_b(cb0), .cla_c0(cc0), .cla_s(cs0), .cla_c4(c40));

   cla_word_sequencer #(.WIDTH(W1), .CLA_LAT(L1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1),
      .cla_a(ca1), .cla_b(cb1), .cla_c0(cc1), .cla_s(cs1), .cla_c4(c41));

   // Behavioural registered CLAs: nibble add, then a pipeline of the given depth.
   logic [4:0] p0 [L0];
   logic [4:0] p1 [L1];
   always @(posedge clk) begin
      p0[0] <= 5'(ca0) + 5'(cb0) + 5'(cc0);
      for (int k = 1; k < L0; k++) p0[k] <= p0[k-1];
      p1[0] <= 5'(ca1) + 5'(cb1) + 5'(cc1);
      for (int k = 1; k < L1; k++) p1[k] <= p1[k-1];
   end
   assign {c40, cs0} = p0[L0-1];
   assign {c41, cs1} = p1[L1-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word-level reference: {ovf, cout, sum} of a+b+c at width w.
   function automatic logic [33:0] refm(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
      logic [63:0] t;
      logic [63:0] m;
      logic [31:0] s;
      logic        co;
      logic        ov;
      m  = (64'd1 << w) - 64'd1;
      t  = 64'(a) + 64'(b) + 64'(c);
      s  = 32'(t & m);
      co = t[w];
      ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
      return {ov, co, s};
   endfunction

   // Carry entering nibble k of a+b+c.
   function automatic logic carry_in(input int k, input logic [31:0] a, input logic [31:0] b,
                                     input logic c);
      logic [63:0] m;
      logic [63:0] t;
      m = (64'd1 << (4 * k)) - 64'd1;
      t = (64'(a) & m) + (64'(b) & m) + 64'(c);
      return t[4 * k];
   endfunction

   // Monitor for DUT0: records accepts, checks latency and pops results on handshake.
   initial begin : mon0
      logic     prev;
      logic [33:0] e;
      int       t;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (iv0 && ir0) acc0_q.push_back(cyc + 1);
            if (ov0 && !prev) begin
               if (acc0_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL lat0: out_valid with no accepted request (cycle %0d)", cyc);
               end else begin
                  t = acc0_q.pop_front();
                  chk("latency0", 32'(cyc - t), 32'(N0 * (L0 + 1)));
               end
            end
            if (ov0 && or0) begin
               if (exp0_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL out0: unexpected result 0x%0h (cycle %0d)", s0, cyc);
               end else begin
                  e = exp0_q.pop_front();
                  chk("sum0", 32'(s0), 32'(e[W0-1:0]));
                  chk("cout0", 32'(co0), 32'(e[32]));
                  chk("ovf0", 32'(of0), 32'(e[33]));
               end
            end
            prev = ov0;
         end
      end
   end

   // Monitor for DUT1.
   initial begin : mon1
      logic     prev;
      logic [33:0] e;
      int       t;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (iv1 && ir1) acc1_q.push_back(cyc + 1);
            if (ov1 && !prev) begin
               if (acc1_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL lat1: out_valid with no accepted request (cycle %0d)", cyc);
               end else begin
                  t = acc1_q.pop_front();
                  chk("latency1", 32'(cyc - t), 32'(N1 * (L1 + 1)));
               end
            end
            if (ov1 && or1) begin
               if (exp1_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL out1: unexpected result 0x%0h (cycle %0d)", s1, cyc);
               end else begin
                  e = exp1_q.pop_front();
                  chk("sum1", 32'(s1), 32'(e[W1-1:0]));
                  chk("cout1", 32'(co1), 32'(e[32]));
               end
            end
            prev = ov1;
         end
      end
   end

   // One DUT0 transaction: checks CLA drive every step cycle, then stalls in DONE for 'stall' cycles.
   task automatic op0(input logic [W0-1:0] a, input logic [W0-1:0] b, input logic c,
                      input int stall);
      logic [33:0] e;
      int n;
      e = refm(W0, 32'(a), 32'(b), c);
      exp0_q.push_back(e);
      a0 = a; b0 = b; ci0 = c; iv0 = 1'b1; or0 = (stall == 0);
      n = 0;
      while (!ir0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("in_ready_idle0", 32'(ir0), 32'd1);
      @(posedge clk); #1;
      iv0 = 1'b0; a0 = W0'($urandom); b0 = W0'($urandom); ci0 = 1'($urandom);
      for (int k = 0; k < N0; k++) begin
         for (int j = 0; j <= L0; j++) begin
            chk("cla_a0", 32'(ca0), 32'((a >> (4 * k)) & 16'hF));
            chk("cla_b0", 32'(cb0), 32'((b >> (4 * k)) & 16'hF));
            chk("cla_c0_0", 32'(cc0), 32'(carry_in(k, 32'(a), 32'(b), c)));
            @(posedge clk); #1;
         end
      end
      n = 0;
      while (!ov0 && n < 20) begin @(posedge clk); #1; n++; end
      chk("out_valid0", 32'(ov0), 32'd1);
      chk("cla_idle_done0", 32'({ca0, cb0, cc0}), 32'd0);
      for (int s = 0; s < stall; s++) begin
         iv0 = 1'b1; a0 = 16'h0F0F; b0 = 16'h0F0F;
         @(posedge clk); #1;
         chk("stall_valid0", 32'(ov0), 32'd1);
         chk("stall_ready0", 32'(ir0), 32'd0);
         chk("stall_sum0", 32'(s0), 32'(e[W0-1:0]));
      end
      iv0 = 1'b0; or0 = 1'b1;
      @(posedge clk); #1;
      chk("ready_after0", 32'(ir0), 32'd1);
      chk("valid_after0", 32'(ov0), 32'd0);
   endtask

   // One DUT1 transaction; result and latency are checked by mon1.
   task automatic op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic c,
                      input int stall);
      int n;
      exp1_q.push_back(refm(W1, 32'(a), 32'(b), c));
      a1 = a; b1 = b; ci1 = c; iv1 = 1'b1; or1 = (stall == 0);
      n = 0;
      while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      iv1 = 1'b0;
      n = 0;
      while (!ov1 && n < 40) begin @(posedge clk); #1; n++; end
      chk("out_valid1", 32'(ov1), 32'd1);
      for (int s = 0; s < stall; s++) begin @(posedge clk); #1; end
      or1 = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int cnt;
      rst = 1'b1;
      iv0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0; or0 = 1'b1;
      iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; or1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_sum", 32'(s0), 32'd0);
      chk("rst_cout_ovf", 32'({co0, of0}), 32'd0);
      chk("rst_cla", 32'({ca0, cb0, cc0}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(ir0), 32'd1);

      op0(16'h1234, 16'h4321, 1'b0, 0);
      op0(16'hFFFF, 16'h0000, 1'b1, 0);
      op0(16'h7FFF, 16'h0001, 1'b0, 0);
      op0(16'h8000, 16'h8000, 1'b0, 0);

      // Backpressure with ignored request, then confirm nothing was queued.
      op0(16'hA5A5, 16'h1111, 1'b1, 5);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (ov0) cnt++;
      end
      chk("no_queued_op0", 32'(cnt), 32'd0);

      // Reset in the middle of an operation.
      a0 = 16'h5A5A; b0 = 16'h3C3C; ci0 = 1'b1; iv0 = 1'b1;
      @(posedge clk); #1;
      iv0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp0_q.delete();
      acc0_q.delete();
      chk("mid_rst_valid", 32'(ov0), 32'd0);
      chk("mid_rst_ready", 32'(ir0), 32'd1);
      chk("mid_rst_cla", 32'({ca0, cb0, cc0}), 32'd0);
      chk("mid_rst_sum", 32'(s0), 32'd0);
      op0(16'h0001, 16'h0001, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         op0(W0'($urandom), W0'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      for (int i = 0; i < 500; i++) begin
         op1(W1'($urandom), W1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("exp0_drained", 32'(exp0_q.size()), 32'd0);
      chk("exp1_drained", 32'(exp1_q.size()), 32'd0);
      chk("acc1_drained", 32'(acc1_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
